// File: rtl/enigma_pkg.sv
// Shared types and helpers for the Enigma keypress/rotor datapath.
// Holds the stepping FSM encoding, the alphabet bound and default turnover notches.
package enigma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_STEP    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_ENCODE  = 3'd4,
    ST_RELEASE = 3'd5
  } step_state_e;

  localparam logic [4:0] ALPHA_MAX = 5'd25;

  localparam int unsigned NOTCH_RIGHT_DEF = 21;
  localparam int unsigned NOTCH_MID_DEF   = 4;

  // Rotor positions live in 0..25, so the wrap is at 25 rather than at 31.
  function automatic logic [4:0] inc26(input logic [4:0] pos);
    return (pos == ALPHA_MAX) ? 5'd0 : pos + 5'd1;
  endfunction

  function automatic logic [4:0] clamp26(input logic [4:0] pos);
    return (pos > ALPHA_MAX) ? 5'd0 : pos;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Key conditioning: two-flop synchroniser, stable-sample debounce counter and
// a one-cycle pulse on each debounced rising edge.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_level,
  output logic key_press_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    // Any sample agreeing with the debounced level restarts the stability run.
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
      press_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_level       = level_q;
  assign key_press_pulse = press_q;

endmodule

// File: rtl/rotor_step_ctrl.sv
// Keypress-to-rotor stepping controller: debounced press advances the three-rotor
// stack with odometer stepping and middle-rotor double-step, then strobes encode.
module rotor_step_ctrl
  import enigma_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SETTLE_CYCLES   = 2,
  parameter int unsigned NOTCH_RIGHT     = NOTCH_RIGHT_DEF,
  parameter int unsigned NOTCH_MID       = NOTCH_MID_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_press,
  input  logic       load,
  input  logic [4:0] init_left,
  input  logic [4:0] init_mid,
  input  logic [4:0] init_right,
  output logic [4:0] pos_left,
  output logic [4:0] pos_mid,
  output logic [4:0] pos_right,
  output logic       step_strobe,
  output logic       encode_valid,
  output logic       busy,
  output logic [2:0] state_out
);

  localparam logic [4:0] NOTCH_R     = 5'(NOTCH_RIGHT);
  localparam logic [4:0] NOTCH_M     = 5'(NOTCH_MID);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic key_level;
  logic press_evt;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk            (clk),
    .reset          (reset),
    .key_raw        (key_press),
    .key_level      (key_level),
    .key_press_pulse(press_evt)
  );

  step_state_e state_q, state_d;
  logic [4:0]  left_q, left_d;
  logic [4:0]  mid_q, mid_d;
  logic [4:0]  right_q, right_d;
  logic [3:0]  settle_cnt_q, settle_cnt_d;
  logic        step_strobe_q, step_strobe_d;
  logic        encode_valid_q, encode_valid_d;
  logic        busy_q, busy_d;

  logic right_at_notch;
  logic mid_at_notch;

  assign right_at_notch = (right_q == NOTCH_R);
  assign mid_at_notch   = (mid_q == NOTCH_M);

  // Strobes are one-cycle pulses with no back-pressure: step_strobe marks the cycle
  // new positions first appear, encode_valid marks the cycle downstream may sample.
  always_comb begin
    state_d        = state_q;
    left_d         = left_q;
    mid_d          = mid_q;
    right_d        = right_q;
    settle_cnt_d   = settle_cnt_q;
    step_strobe_d  = 1'b0;
    encode_valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (press_evt) begin
          // Stepping decisions all use pre-step values; mid_at_notch gives the double-step.
          state_d       = ST_STEP;
          step_strobe_d = 1'b1;
          right_d       = inc26(right_q);
          if (right_at_notch || mid_at_notch) mid_d = inc26(mid_q);
          if (mid_at_notch) left_d = inc26(left_q);
        end else if (load) begin
          state_d = ST_LOAD;
          left_d  = clamp26(init_left);
          mid_d   = clamp26(init_mid);
          right_d = clamp26(init_right);
        end
      end
      ST_LOAD: state_d = ST_IDLE;
      ST_STEP: begin
        state_d      = ST_SETTLE;
        settle_cnt_d = '0;
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d        = ST_ENCODE;
          encode_valid_d = 1'b1;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      ST_ENCODE: state_d = ST_RELEASE;
      ST_RELEASE: begin
        if (!key_level) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      left_q         <= 5'd0;
      mid_q          <= 5'd0;
      right_q        <= 5'd0;
      settle_cnt_q   <= 4'd0;
      step_strobe_q  <= 1'b0;
      encode_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      left_q         <= left_d;
      mid_q          <= mid_d;
      right_q        <= right_d;
      settle_cnt_q   <= settle_cnt_d;
      step_strobe_q  <= step_strobe_d;
      encode_valid_q <= encode_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign pos_left     = left_q;
  assign pos_mid      = mid_q;
  assign pos_right    = right_q;
  assign step_strobe  = step_strobe_q;
  assign encode_valid = encode_valid_q;
  assign busy         = busy_q;
  assign state_out    = state_q;

endmodule
